// File: rtl/bus_package.sv
// Shared request/response bus definitions: tag and command widths and the bus command encoding.
package bus_package;

    localparam int unsigned TAG_WIDTH = 4;
    localparam int unsigned CMD_WIDTH = 2;

    typedef enum logic [CMD_WIDTH-1:0] {
        bus_idle       = 2'd0,
        bus_read       = 2'd1,
        bus_write      = 2'd2,
        bus_invalidate = 2'd3
    } bus_command_e;

endpackage

// File: rtl/line_fetch_master.sv
// Fetches one 128-bit line over a split request/response bus with nack retry and backoff.
// Define LINE_FETCH_TIMEOUT_EN to bound the response wait to TIMEOUT_CYCLES.
module line_fetch_master
    import bus_package::*;
#(
    parameter int unsigned MASTER_TAG     = 1,
    parameter int unsigned BACKOFF_CYCLES = 4,
    parameter int unsigned MAX_RETRIES    = 7,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_address,
    output logic                 fetch_ready,
    output logic                 fetch_done,
    output logic                 fetch_error,
    output logic [127:0]         fetch_data,
    output logic                 request_breq,
    input  logic                 request_bgnt,
    output logic                 request_oe,
    output logic [31:0]          request_address,
    output logic [CMD_WIDTH-1:0] request_command,
    output logic [TAG_WIDTH-1:0] request_tag,
    input  logic                 nack,
    input  logic                 response_oe,
    input  logic [TAG_WIDTH-1:0] response_tag,
    input  logic [127:0]         response_data
);

    localparam int unsigned RetryWidth   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned BackoffWidth = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, BACKOFF, WAIT, DONE} state_e;

    state_e                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [RetryWidth-1:0]   retry_q, retry_d;
    logic [BackoffWidth-1:0] backoff_q, backoff_d;
    logic                    error_q, error_d;
    logic [127:0]            data_q, data_d;
    logic                    response_hit;

    assign response_hit = response_oe && (response_tag == TAG_WIDTH'(MASTER_TAG));

`ifdef LINE_FETCH_TIMEOUT_EN
    localparam int unsigned TimeoutWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TimeoutWidth-1:0] timeout_q, timeout_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        retry_d   = retry_q;
        backoff_d = backoff_q;
        error_d   = error_q;
        data_d    = data_q;
`ifdef LINE_FETCH_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_valid) begin
                    addr_d  = {fetch_address[31:4], 4'h0};
                    retry_d = '0;
                    error_d = 1'b0;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (request_bgnt) state_d = ISSUE;
            end
            ISSUE: begin
                if (!nack) begin
`ifdef LINE_FETCH_TIMEOUT_EN
                    timeout_d = '0;
`endif
                    state_d = WAIT;
                end else if (retry_q == RetryWidth'(MAX_RETRIES)) begin
                    error_d = 1'b1;
                    data_d  = '0;
                    state_d = DONE;
                end else begin
                    retry_d   = retry_q + 1'b1;
                    backoff_d = '0;
                    state_d   = BACKOFF;
                end
            end
            BACKOFF: begin
                if (backoff_q == BackoffWidth'(BACKOFF_CYCLES - 1)) state_d = ARB;
                else backoff_d = backoff_q + 1'b1;
            end
            WAIT: begin
                if (response_hit) begin
                    data_d  = response_data;
                    state_d = DONE;
                end
`ifdef LINE_FETCH_TIMEOUT_EN
                // Count lands on TIMEOUT_CYCLES as we leave the last permitted WAIT cycle
                else if (timeout_q == TimeoutWidth'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    data_d  = '0;
                    state_d = DONE;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            retry_q   <= '0;
            backoff_q <= '0;
            error_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            retry_q   <= retry_d;
            backoff_q <= backoff_d;
            error_q   <= error_d;
            data_q    <= data_d;
        end
    end

`ifdef LINE_FETCH_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) timeout_q <= '0;
        else        timeout_q <= timeout_d;
    end
`endif

    // Gating with reset keeps ready low while reset is held even though state is IDLE
    assign fetch_ready     = reset && (state_q == IDLE);
    assign fetch_done      = (state_q == DONE);
    assign fetch_error     = fetch_done && error_q;
    assign fetch_data      = data_q;
    assign request_breq    = (state_q == ARB);
    assign request_oe      = (state_q == ISSUE);
    assign request_address = request_oe ? addr_q : '0;
    assign request_command = request_oe ? CMD_WIDTH'(bus_read) : '0;
    assign request_tag     = request_oe ? TAG_WIDTH'(MASTER_TAG) : '0;

endmodule

// File: tb/tb_line_fetch_master.sv
// Randomized scoreboard bench for line_fetch_master; covers the timeout path when
// LINE_FETCH_TIMEOUT_EN is defined.
module tb_line_fetch_master;
    import bus_package::*;

    localparam int unsigned MTAG    = 1;
    localparam int unsigned BACKOFF = 4;
    localparam int unsigned MAXR    = 7;
    localparam int unsigned TMO     = 255;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 fetch_valid = 1'b0;
    logic [31:0]          fetch_address = '0;
    logic                 fetch_ready, fetch_done, fetch_error;
    logic [127:0]         fetch_data;
    logic                 request_breq, request_oe;
    logic                 request_bgnt = 1'b0;
    logic [31:0]          request_address;
    logic [CMD_WIDTH-1:0] request_command;
    logic [TAG_WIDTH-1:0] request_tag;
    logic                 nack = 1'b0;
    logic                 response_oe = 1'b0;
    logic [TAG_WIDTH-1:0] response_tag = '0;
    logic [127:0]         response_data = '0;

    line_fetch_master #(
        .MASTER_TAG    (MTAG),
        .BACKOFF_CYCLES(BACKOFF),
        .MAX_RETRIES   (MAXR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_valid    (fetch_valid),
        .fetch_address  (fetch_address),
        .fetch_ready    (fetch_ready),
        .fetch_done     (fetch_done),
        .fetch_error    (fetch_error),
        .fetch_data     (fetch_data),
        .request_breq   (request_breq),
        .request_bgnt   (request_bgnt),
        .request_oe     (request_oe),
        .request_address(request_address),
        .request_command(request_command),
        .request_tag    (request_tag),
        .nack           (nack),
        .response_oe    (response_oe),
        .response_tag   (response_tag),
        .response_data  (response_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           err;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [31:0]  exp_addr = '0;
    logic [127:0] hold_data = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each completion and polices the request bus.
    always @(negedge clock) begin
        if (!reset) begin
            hold_data = '0;
        end else begin
            if (fetch_done) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(fetch_error == mon_e.err, "done_error", fetch_error, mon_e.err);
                    check(fetch_data == mon_e.data, "done_data", fetch_data, mon_e.data);
                    check(cyc == mon_e.cyc, "done_cycle", cyc, mon_e.cyc);
                    hold_data = mon_e.data;
                end
            end else begin
                check(fetch_data == hold_data, "data_hold", fetch_data, hold_data);
            end
            if (request_oe) begin
                check(request_address == exp_addr, "issue_addr", request_address, exp_addr);
                check(request_tag == TAG_WIDTH'(MTAG), "issue_tag", request_tag, MTAG);
                check(request_command == CMD_WIDTH'(bus_read), "issue_cmd", request_command,
                      bus_read);
            end else begin
                check({request_address, request_command, request_tag} == '0, "bus_idle_zero",
                      {request_address, request_command, request_tag}, 0);
            end
        end
    end

    // Drives one fetch while playing arbiter and slave; pushes the expected outcome first.
    task automatic do_fetch(input logic [31:0] addr, input int nacks, input int gdly,
                            input int rdly, input bit wrong, input bit no_rsp,
                            input logic [127:0] line);
        exp_t e;
        int   t, attempts, n;
        bit   err;
        err      = (nacks > int'(MAXR)) || no_rsp;
        attempts = (nacks > int'(MAXR)) ? int'(MAXR) + 1 : nacks + 1;
        @(negedge clock);
        check(fetch_ready == 1'b1, "ready_in_idle", fetch_ready, 1);
        t     = cyc;
        e.err = err;
        e.data = err ? '0 : line;
        e.cyc = t + 1 + attempts * (gdly + 2) + (attempts - 1) * int'(BACKOFF)
              + (no_rsp ? int'(TMO) : (err ? 0 : rdly + int'(wrong) + 1));
        exp_q.push_back(e);
        exp_addr      = {addr[31:4], 4'h0};
        fetch_valid   = 1'b1;
        fetch_address = addr;
        @(negedge clock);
        for (int a = 0; a < attempts; a++) begin
            n = 0;
            while (!request_breq && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (a > 0) check(n == int'(BACKOFF), "backoff_len", n, BACKOFF);
            if (!request_breq) begin
                check(1'b0, "breq_timeout", 0, 1);
                exp_q.delete();
                return;
            end
            check(fetch_ready == 1'b0, "ready_busy", fetch_ready, 0);
            // A request offered while busy must not disturb the captured address
            fetch_valid   = 1'b1;
            fetch_address = ~addr;
            repeat (gdly) @(negedge clock);
            fetch_valid  = 1'b0;
            request_bgnt = 1'b1;
            @(negedge clock);
            request_bgnt = 1'b0;
            check(request_oe == 1'b1, "issue_oe", request_oe, 1);
            nack = (a < nacks);
            @(negedge clock);
            nack = 1'b0;
        end
        if (!err) begin
            repeat (rdly) @(negedge clock);
            if (wrong) begin
                response_oe   = 1'b1;
                response_tag  = TAG_WIDTH'(2);
                response_data = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clock);
            end
            response_oe   = 1'b1;
            response_tag  = TAG_WIDTH'(MTAG);
            response_data = line;
            @(negedge clock);
            response_oe = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check(1'b0, "done_missing", 0, 1);
            exp_q.delete();
        end
    endtask

    initial begin
        int r, nk;
        logic [127:0] pattern;
        pattern = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        #1;
        check({fetch_ready, fetch_done, fetch_error, request_breq, request_oe} == '0,
              "reset_ctrl_zero", {fetch_ready, fetch_done, fetch_error, request_breq, request_oe},
              0);
        check(fetch_data == '0, "reset_data_zero", fetch_data, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check(fetch_ready == 1'b1, "ready_after_reset", fetch_ready, 1);

        do_fetch(32'h0000_1237, 0, 0, 0, 1'b0, 1'b0, pattern);
        do_fetch(32'h0000_2000, 2, 0, 0, 1'b0, 1'b0, ~pattern);
        do_fetch(32'h0000_3004, int'(MAXR) + 1, 0, 0, 1'b0, 1'b0, pattern);
        do_fetch(32'h0000_400F, 0, 1, 1, 1'b1, 1'b0, {4{32'hA5A5_5A5A}});

        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            nk = (r < 5) ? 0 : ((r < 8) ? $urandom_range(1, MAXR) : int'(MAXR) + 1);
            do_fetch($urandom, nk, $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom, $urandom, $urandom});
        end

`ifdef LINE_FETCH_TIMEOUT_EN
        do_fetch(32'h0000_5550, 0, 0, 0, 1'b0, 1'b1, pattern);
`endif

        // Reset in WAIT: the transaction must vanish, a late response must not be captured
        @(negedge clock);
        exp_addr      = 32'h0000_ABC0;
        fetch_valid   = 1'b1;
        fetch_address = 32'h0000_ABC4;
        @(negedge clock);
        fetch_valid  = 1'b0;
        request_bgnt = 1'b1;
        @(negedge clock);
        request_bgnt = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check({fetch_ready, fetch_done, fetch_error, request_breq, request_oe} == '0,
              "midreset_ctrl_zero", {fetch_ready, fetch_done, fetch_error, request_breq,
              request_oe}, 0);
        check(fetch_data == '0, "midreset_data_zero", fetch_data, 0);
        @(negedge clock);
        @(negedge clock);
        response_oe   = 1'b1;
        response_tag  = TAG_WIDTH'(MTAG);
        response_data = pattern;
        reset         = 1'b1;
        #1;
        check(fetch_ready == 1'b1, "ready_after_midreset", fetch_ready, 1);
        repeat (2) @(negedge clock);
        response_oe = 1'b0;
        repeat (10) @(negedge clock);
        check(fetch_ready == 1'b1, "idle_after_midreset", fetch_ready, 1);
        check(fetch_data == '0, "no_late_capture", fetch_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/line_fetch_master.md
LINE_FETCH_MASTER -- requirements
Module: line_fetch_master

Interface
REQ-001 SHALL have parameter MASTER_TAG, default 1, meaning the tag driven on the request bus and matched on the response bus.
REQ-002 SHALL have parameter BACKOFF_CYCLES, default 4, meaning the idle cycles after a nack before re-arbitrating.
REQ-003 SHALL have parameter MAX_RETRIES, default 7, meaning the nacks tolerated before the fetch fails.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the response wait limit (only with LINE_FETCH_TIMEOUT_EN).
REQ-005 SHALL provide the following ports, one clock, with reset asynchronous and active-low:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- fetch_valid  in  1  client fetch request.
- fetch_address  in  32  client byte address.
- fetch_ready  out  1  master can accept a request.
- fetch_done  out  1  one-cycle completion pulse.
- fetch_error  out  1  qualifies fetch_done as failed.
- fetch_data  out  128  returned line, valid with fetch_done.
- request_breq  out  1  request-bus arbitration request.
- request_bgnt  in  1  request-bus grant.
- request_oe  out  1  request-bus drive enable.
- request_address  out  32  line address.
- request_command  out  CMD_WIDTH  bus command.
- request_tag  out  TAG_WIDTH  bus tag.
- nack  in  1  wired-OR slave nack.
- response_oe  in  1  response-bus valid.
- response_tag  in  TAG_WIDTH  response tag.
- response_data  in  128  response line.

Function
REQ-006 SHALL implement the states IDLE, ARB, ISSUE, BACKOFF, WAIT and DONE.
REQ-007 IDLE SHALL assert fetch_ready=1; on fetch_valid it SHALL capture fetch_address with bits [3:0] forced to 0, clear the retry count, and go to ARB; fetch_ready SHALL be 0 in all other states.
REQ-008 ARB SHALL assert request_breq=1; on request_bgnt=1 it SHALL go to ISSUE the next cycle.
REQ-009 ISSUE SHALL last exactly one cycle and drive request_oe=1, the captured address, request_command=bus_read and request_tag=MASTER_TAG.
REQ-010 When request_oe=0, request_address, request_command and request_tag SHALL be driven to 0.
REQ-011 nack SHALL be sampled only in ISSUE; with nack=0 the state SHALL go to WAIT.
REQ-012 With nack=1 and retry count < MAX_RETRIES, the retry count SHALL increment and the state SHALL go to BACKOFF.
REQ-013 With nack=1 and retry count = MAX_RETRIES, the state SHALL go to DONE with the error flag set.
REQ-014 BACKOFF SHALL wait exactly BACKOFF_CYCLES cycles and then go to ARB.
REQ-015 WAIT SHALL capture response_data into fetch_data and go to DONE when response_oe=1 and response_tag=MASTER_TAG; responses carrying other tags SHALL be ignored.
REQ-016 DONE SHALL pulse fetch_done=1 for one cycle, with fetch_error reflecting the error flag, then go to IDLE.
REQ-017 fetch_data SHALL hold its value until the next successful capture; a failed fetch SHALL set fetch_data to 0.
REQ-018 A fetch_valid asserted outside IDLE SHALL be ignored.
REQ-019 Minimum latency, with grant in the first ARB cycle and the response in the first WAIT cycle, SHALL be 4 cycles from fetch_valid to fetch_done.

Reset
REQ-020 Assertion of reset SHALL immediately force state IDLE, retry count 0, all counters 0, and fetch_data 0.
REQ-021 During reset, every output SHALL be 0 except fetch_ready, which SHALL be 0 in reset and 1 in the first IDLE cycle after release.
REQ-022 Reset mid-transaction SHALL abandon the transaction, with no fetch_done and no late capture.

Configuration
REQ-023 With LINE_FETCH_TIMEOUT_EN defined, WAIT SHALL count cycles, and when the count reaches TIMEOUT_CYCLES it SHALL go to DONE with fetch_error=1 and fetch_data=0.
REQ-024 Without LINE_FETCH_TIMEOUT_EN, WAIT SHALL wait indefinitely and no timeout counter SHALL exist.

Structure
REQ-025 TAG_WIDTH, CMD_WIDTH and the bus command enum including bus_read SHALL come from bus_package; the state enum SHALL stay local.
REQ-026 The block SHALL be a single module with no sub-module.

Verification
REQ-027 Grant immediate, nack=0, response tag=1 with data 0x0123...CDEF one cycle later -> fetch_done at cycle 4, fetch_error=0, fetch_data matches.
REQ-028 fetch_address=0x0000_1237 -> request_address=0x0000_1230 in the ISSUE cycle, request_tag=1, request_command=bus_read.
REQ-029 nack=1 on the first two issues, then 0 -> three ISSUE cycles, each retry preceded by 4 BACKOFF cycles, then normal completion.
REQ-030 nack=1 on every issue -> 8 ISSUE cycles, then fetch_done=1, fetch_error=1, fetch_data=0.
REQ-031 Response with tag=2 followed by tag=1 -> the tag=2 data is ignored and the tag=1 data is returned.
REQ-032 Reset asserted during WAIT, then a tag=1 response after release -> no fetch_done, state IDLE; with LINE_FETCH_TIMEOUT_EN and no response, fetch_error=1 is reported 255 cycles after entering WAIT.
